nios_dbg_scan_master: RTL and testbench

//  Single-clock scan initiator that drives the Nios II debug-slave virtual-JTAG port (ir_in, tck, tdi, uir/cdr/sdr/udr/rti)
//  and collects tdo/ir_out. Takes one command (IR code + DR word), runs UIR->CDR->SDR*N->UDR->RTI, returns the shifted-out word.

---
 rtl/nios_dbg_pkg.sv | 19 +
 rtl/nios_dbg_tck_phase.sv | 46 ++++
 rtl/nios_dbg_scan_master.sv | 164 ++++++++++++++++
 tb/tb_nios_dbg_scan_master.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_dbg_pkg.sv
// Shared state encoding and IR codes for the Nios II debug-slave scan initiator.
package nios_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RTI
  } scan_state_e;

  localparam int unsigned IR_OCIMEM        = 0;
  localparam int unsigned IR_TRACE         = 1;
  localparam int unsigned IR_BREAK         = 2;
  localparam int unsigned IR_TRACECTRL     = 3;
  localparam int unsigned DR_WIDTH_DEFAULT = 38;

endpackage

// File: rtl/nios_dbg_tck_phase.sv
// TCK generator: low half then high half, TCK_DIV clk each, with strobes
// flagging the clk edge on which tck rises or falls.
module nios_dbg_tck_phase #(
  parameter int unsigned TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  input  logic run,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int unsigned      CNT_W     = $clog2(2 * TCK_DIV);
  localparam logic [CNT_W-1:0] RISE_AT   = CNT_W'(TCK_DIV - 1);
  localparam logic [CNT_W-1:0] FALL_AT   = CNT_W'(2 * TCK_DIV - 1);
  localparam logic [CNT_W-1:0] HIGH_FROM = CNT_W'(TCK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tck_q, tck_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || !run || (cnt_q == FALL_AT)) begin
      cnt_d = '0;
    end
    // tck is registered from the next count so it never glitches
    tck_d = (cnt_d >= HIGH_FROM);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck      = tck_q;
  assign fall_stb = run && (cnt_q == FALL_AT);
  assign rise_stb = run && (cnt_q == RISE_AT);

endmodule

// File: rtl/nios_dbg_scan_master.sv
// Nios II debug-slave scan initiator: one command runs UIR->CDR->SDR*N->UDR->RTI
// and returns the tdo word shifted out of the slave plus the sampled IR status.
module nios_dbg_scan_master
  import nios_dbg_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DR_WIDTH_DEFAULT,
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  input  logic                cmd_ir_only,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir,
  output logic                busy,
  output logic                vj_tck,
  output logic                vj_tdi,
  input  logic                vj_tdo,
  output logic [IR_WIDTH-1:0] vj_ir_in,
  input  logic [IR_WIDTH-1:0] vj_ir_out,
  output logic                vj_uir,
  output logic                vj_cdr,
  output logic                vj_sdr,
  output logic                vj_udr,
  output logic                vj_rti
);

  localparam int unsigned      CNT_W    = $clog2(DR_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DR_WIDTH - 1);

  scan_state_e         state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [DR_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic                ir_only_q, ir_only_d;
  logic [DR_WIDTH-1:0] cap_q, cap_d;
  logic [IR_WIDTH-1:0] ir_cap_q, ir_cap_d;
  logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
  logic                rsp_valid_q, rsp_valid_d;

  logic                accept;
  logic                tck, fall_stb, rise_stb;
  logic [DR_WIDTH:0]   cap_shift;

  nios_dbg_tck_phase #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_phase (
    .clk      (clk),
    .reset_n  (reset_n),
    .restart  (accept),
    .run      (state_q != IDLE),
    .tck      (tck),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  // New tdo sample enters at the MSB so the first sample ends up in bit 0
  assign cap_shift = {vj_tdo, cap_q};

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    data_d      = data_q;
    bit_d       = bit_q;
    ir_only_d   = ir_only_q;
    cap_d       = cap_q;
    ir_cap_d    = ir_cap_q;
    rsp_data_d  = rsp_data_q;
    rsp_ir_d    = rsp_ir_q;
    rsp_valid_d = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_d   = UIR;
          ir_d      = cmd_ir;
          data_d    = cmd_data;
          ir_only_d = cmd_ir_only;
          bit_d     = '0;
          cap_d     = '0;
        end
      end
      UIR: begin
        if (rise_stb) ir_cap_d = vj_ir_out;
        if (fall_stb) state_d = ir_only_q ? RTI : CDR;
      end
      CDR: begin
        if (fall_stb) state_d = SDR;
      end
      SDR: begin
        if (rise_stb) cap_d = cap_shift[DR_WIDTH:1];
        if (fall_stb) begin
          data_d = data_q >> 1;
          if (bit_q == LAST_BIT) begin
            state_d = UDR;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end
      UDR: begin
        if (fall_stb) state_d = RTI;
      end
      RTI: begin
        if (fall_stb) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = cap_q;
          rsp_ir_d    = ir_cap_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      data_q      <= '0;
      bit_q       <= '0;
      ir_only_q   <= 1'b0;
      cap_q       <= '0;
      ir_cap_q    <= '0;
      rsp_data_q  <= '0;
      rsp_ir_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      data_q      <= data_d;
      bit_q       <= bit_d;
      ir_only_q   <= ir_only_d;
      cap_q       <= cap_d;
      ir_cap_q    <= ir_cap_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ir_q    <= rsp_ir_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ir    = rsp_ir_q;
  assign vj_tck    = tck;
  assign vj_tdi    = (state_q == SDR) && data_q[0];
  assign vj_ir_in  = ir_q;
  assign vj_uir    = (state_q == UIR);
  assign vj_cdr    = (state_q == CDR);
  assign vj_sdr    = (state_q == SDR);
  assign vj_udr    = (state_q == UDR);
  assign vj_rti    = (state_q == RTI);

endmodule

// File: tb/tb_nios_dbg_scan_master.sv
// Bench for nios_dbg_scan_master: loopback and shift-register slave models,
// table-driven commands with a response scoreboard, plus corner sequences.
module tb_nios_dbg_scan_master;
  import nios_dbg_pkg::*;

  localparam int unsigned DRW = 38;
  localparam int unsigned LAT = (DRW + 4) * 2 * 4;

  typedef struct {
    logic [DRW-1:0] data;
    logic [1:0]     ir;
    logic           ir_only;
    logic           loop;
    logic [DRW-1:0] sr_init;
    logic [1:0]     ir_out;
    logic [DRW-1:0] exp_data;
    logic [1:0]     exp_ir;
    int             lat;
    logic           chk_data;
    logic           chk_sr;
  } vec_t;

  typedef struct {
    logic [DRW-1:0] data;
    logic [1:0]     ir_rsp;
    logic [1:0]     ir;
    int             lat;
    int             acc;
    logic           chk_data;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           cmd_valid = 1'b0, cmd_ready, cmd_ir_only = 1'b0;
  logic [1:0]     cmd_ir = '0;
  logic [DRW-1:0] cmd_data = '0;
  logic           rsp_valid, busy, vj_tck, vj_tdi, vj_tdo;
  logic [DRW-1:0] rsp_data;
  logic [1:0]     rsp_ir, vj_ir_in;
  logic [1:0]     vj_ir_out = '0;
  logic           vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti;

  logic           f_cmd_valid = 1'b0, f_cmd_ready, f_cmd_ir_only = 1'b0;
  logic [1:0]     f_cmd_ir = '0;
  logic [DRW-1:0] f_cmd_data = '0;
  logic           f_rsp_valid, f_busy, f_vj_tck, f_vj_tdi;
  logic [DRW-1:0] f_rsp_data;
  logic [1:0]     f_rsp_ir, f_vj_ir_in;
  logic [1:0]     f_vj_ir_out = '0;
  logic           f_vj_uir, f_vj_cdr, f_vj_sdr, f_vj_udr, f_vj_rti;

  logic           loop_v = 1'b1;
  logic [DRW-1:0] sr_init_v = '0;
  logic [DRW-1:0] sr = '0;
  logic [DRW-1:0] sr_at_udr = '0;
  int             n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0;
  int             cyc = 0;
  int             n_checks = 0, n_fail = 0;
  exp_t           exp_q[$];
  vec_t           tbl[5];

  always #5 clk = ~clk;

  nios_dbg_scan_master u_dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_ir_only(cmd_ir_only),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ir(rsp_ir), .busy(busy),
    .vj_tck(vj_tck), .vj_tdi(vj_tdi), .vj_tdo(vj_tdo), .vj_ir_in(vj_ir_in),
    .vj_ir_out(vj_ir_out), .vj_uir(vj_uir), .vj_cdr(vj_cdr), .vj_sdr(vj_sdr),
    .vj_udr(vj_udr), .vj_rti(vj_rti)
  );

  nios_dbg_scan_master #(.TCK_DIV(1)) u_dut_fast (
    .clk(clk), .reset_n(reset_n), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
    .cmd_ir(f_cmd_ir), .cmd_data(f_cmd_data), .cmd_ir_only(f_cmd_ir_only),
    .rsp_valid(f_rsp_valid), .rsp_data(f_rsp_data), .rsp_ir(f_rsp_ir), .busy(f_busy),
    .vj_tck(f_vj_tck), .vj_tdi(f_vj_tdi), .vj_tdo(1'b0), .vj_ir_in(f_vj_ir_in),
    .vj_ir_out(f_vj_ir_out), .vj_uir(f_vj_uir), .vj_cdr(f_vj_cdr), .vj_sdr(f_vj_sdr),
    .vj_udr(f_vj_udr), .vj_rti(f_vj_rti)
  );

  // Slave model: loads its register at CDR, shifts tdi in at the MSB on each SDR tck rise
  assign vj_tdo = loop_v ? vj_tdi : sr[0];

  always @(posedge vj_tck) begin
    if (vj_uir) n_uir++;
    if (vj_cdr) n_cdr++;
    if (vj_sdr) n_sdr++;
    if (vj_udr) n_udr++;
    if (vj_rti) n_rti++;
    if (vj_cdr) sr <= sr_init_v;
    else if (vj_sdr) sr <= {vj_tdi, sr[DRW-1:1]};
  end

  always @(posedge vj_udr) sr_at_udr = sr;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    check({tag, "_vj_outputs"},
          {vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti, vj_tck, vj_tdi, vj_ir_in}, '0);
    check({tag, "_rsp"}, {rsp_valid, rsp_ir, rsp_data}, '0);
  endtask

  task automatic send(input vec_t v, input bit hold, output exp_t e, output bit ok);
    @(negedge clk);
    sr_init_v   = v.sr_init;
    vj_ir_out   = v.ir_out;
    loop_v      = v.loop;
    cmd_data    = v.data;
    cmd_ir      = v.ir;
    cmd_ir_only = v.ir_only;
    cmd_valid   = 1'b1;
    for (int c = 0; c < 800 && !cmd_ready; c++) @(negedge clk);
    check("cmd_accept", cmd_ready, 1'b1);
    ok = cmd_ready;
    e = '{data: v.exp_data, ir_rsp: v.exp_ir, ir: v.ir, lat: v.lat, acc: cyc + 1,
          chk_data: v.chk_data};
    if (!ok) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int rc);
    exp_t e;
    rc = -1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rc = cyc;
        break;
      end
    end
    check("rsp_seen", rsp_valid, 1'b1);
    if (!rsp_valid) return;
    check("sb_has_entry", exp_q.size() != 0, 1'b1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    if (e.chk_data) check("rsp_data", rsp_data, e.data);
    check("rsp_ir", rsp_ir, e.ir_rsp);
    check("latency", rc - e.acc, e.lat);
    check("vj_ir_in", vj_ir_in, e.ir);
  endtask

  task automatic run_vec(input vec_t v);
    int   bu, bc, bs, bd, br, rc;
    exp_t e;
    bit   ok;
    bu = n_uir; bc = n_cdr; bs = n_sdr; bd = n_udr; br = n_rti;
    send(v, 1'b0, e, ok);
    if (ok) exp_q.push_back(e);
    wait_rsp(rc);
    @(negedge clk);
    check("rsp_pulse_one_cycle", rsp_valid, 1'b0);
    check("sdr_tck_rises", n_sdr - bs, v.ir_only ? 0 : DRW);
    check("state_periods",
          {8'(n_uir - bu), 8'(n_cdr - bc), 8'(n_udr - bd), 8'(n_rti - br)},
          {8'd1, v.ir_only ? 8'd0 : 8'd1, v.ir_only ? 8'd0 : 8'd1, 8'd1});
    if (v.chk_sr) check("slave_sr_at_udr", sr_at_udr, v.data);
  endtask

  initial begin
    int   pulses, highs, rc, rc2, lat, nu, nr, nx, nh, base;
    logic first_tck;
    vec_t a, b;
    exp_t ea, eb, er;
    bit   ok;

    tbl[0] = '{38'h2A_5A5A_A5A5, 2'(IR_BREAK), 1'b0, 1'b1, '0, 2'b01,
               38'h2A_5A5A_A5A5, 2'b01, LAT, 1'b1, 1'b0};
    tbl[1] = '{38'h00_0000_0000, 2'(IR_TRACE), 1'b0, 1'b0, 38'h3F_0000_0001, 2'b10,
               38'h3F_0000_0001, 2'b10, LAT, 1'b1, 1'b1};
    tbl[2] = '{38'h15_5555_5555, 2'(IR_OCIMEM), 1'b0, 1'b1, '0, 2'b11,
               38'h15_5555_5555, 2'b11, LAT, 1'b1, 1'b0};
    tbl[3] = '{38'h3F_FFFF_FFFF, 2'(IR_TRACECTRL), 1'b1, 1'b1, '0, 2'b10,
               '0, 2'b10, 4 * 2 * 4 / 2, 1'b0, 1'b0};
    tbl[4] = '{38'h01_2345_6789, 2'(IR_BREAK), 1'b0, 1'b0, 38'h3F_FFFF_FFFF, 2'b00,
               38'h3F_FFFF_FFFF, 2'b00, LAT, 1'b1, 1'b1};

    #1 reset_n = 1'b0;
    #2;
    chk_quiet("in_reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_quiet("after_reset");
    check("reset_cmd_ready", {cmd_ready, busy}, 2'b10);

    pulses = 0; highs = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      pulses += int'(rsp_valid);
      highs  += int'(vj_tck | vj_uir | vj_cdr | vj_sdr | vj_udr | vj_rti);
    end
    check("idle_rsp_pulses", pulses, 0);
    check("idle_vj_activity", highs, 0);

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // IR-only command on the TCK_DIV=1 instance
    f_vj_ir_out = 2'b01;
    @(negedge clk);
    f_cmd_ir = 2'(IR_TRACECTRL); f_cmd_ir_only = 1'b1; f_cmd_data = '1; f_cmd_valid = 1'b1;
    check("fast_ready", f_cmd_ready, 1'b1);
    base = cyc + 1;
    @(posedge clk);
    #1 f_cmd_valid = 1'b0;
    lat = -1; nu = 0; nr = 0; nx = 0; nh = 0; first_tck = 1'bx;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) first_tck = f_vj_tck;
      if (f_rsp_valid) begin
        lat = cyc - base;
        break;
      end
      nu += int'(f_vj_uir);
      nr += int'(f_vj_rti);
      nx += int'(f_vj_cdr | f_vj_sdr | f_vj_udr);
      nh += int'(f_vj_tck);
    end
    check("fast_latency", lat, 4);
    check("fast_periods", {8'(nu), 8'(nr), 8'(nx), 8'(nh)}, {8'd2, 8'd2, 8'd0, 8'd2});
    check("fast_tck_low_first", first_tck, 1'b0);
    check("fast_ir", {f_rsp_ir, f_vj_ir_in}, {2'b01, 2'(IR_TRACECTRL)});

    // Back-to-back: cmd_valid held, second command taken in the rsp_valid cycle
    a = tbl[0]; a.ir_out = 2'b11; a.exp_ir = 2'b11;
    b = tbl[2];
    send(a, 1'b1, ea, ok);
    if (ok) exp_q.push_back(ea);
    cmd_data = b.data; cmd_ir = b.ir; cmd_ir_only = 1'b0;
    wait_rsp(rc);
    @(negedge clk);
    check("b2b_accept_in_rsp_cycle", busy, 1'b1);
    check("b2b_ir_in", vj_ir_in, b.ir);
    check("rsp_data_held", rsp_data, a.exp_data);
    cmd_valid = 1'b0;
    eb = '{data: b.exp_data, ir_rsp: 2'b11, ir: b.ir, lat: LAT, acc: rc + 1, chk_data: 1'b1};
    exp_q.push_back(eb);
    wait_rsp(rc2);
    check("b2b_total", rc2 - ea.acc, 2 * LAT + 1);

    // Reset in the middle of the DR scan
    send(tbl[0], 1'b0, er, ok);
    base = n_sdr;
    for (int c = 0; c < 1000 && (n_sdr - base) < 17; c++) @(negedge clk);
    check("reached_sdr_bit17", n_sdr - base, 17);
    reset_n = 1'b0;
    #1;
    chk_quiet("midscan_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1'b1);
    run_vec(tbl[4]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
